// File: rtl/arc4_pkg.sv
// Shared types and helpers for the ARC4 pipeline stages.
package arc4_pkg;

  localparam int KEY_BYTES = 3;
  localparam int S_SIZE    = 256;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    WT_I,
    CAP_I,
    WT_J,
    CAP_J,
    WR_I,
    WR_J,
    DONE
  } ksa_state_t;

  // Key byte 0 is the most significant byte of the key word.
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                          input logic [1:0]             idx);
    key_byte = key[8*(KEY_BYTES-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/arc4_ksa.sv
// ARC4 key-scheduling stage: runs the 256-step swap loop over S held in an
// external single-port RAM with a registered address (one wait state per read).
module arc4_ksa
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);

  ksa_state_t             state;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             i;
  logic [7:0]             j;
  logic [7:0]             si;
  logic [1:0]             kidx;   // i mod KEY_BYTES, tracked alongside i
  logic [7:0]             j_next;

  // New j from the S[i] value currently on the RAM output.
  always_comb begin
    j_next = j + rddata + key_byte(key_q, kidx);
  end

  // Main sequencer. Each read address is held for the read state plus both
  // following states, so rddata is sampled two cycles after it was presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rdy    <= 1'b1;
      wren   <= 1'b0;
      addr   <= 8'd0;
      wrdata <= 8'd0;
      i      <= 8'd0;
      j      <= 8'd0;
      si     <= 8'd0;
      kidx   <= 2'd0;
      key_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wren <= 1'b0;
          if (rdy && en) begin
            key_q <= key;
            i     <= 8'd0;
            j     <= 8'd0;
            kidx  <= 2'd0;
            addr  <= 8'd0;
            rdy   <= 1'b0;
            state <= RD_I;
          end
        end
        RD_I: begin
          addr  <= i;
          wren  <= 1'b0;
          state <= WT_I;
        end
        WT_I: state <= CAP_I;
        CAP_I: begin
          si    <= rddata;
          j     <= j_next;
          addr  <= j_next;
          state <= WT_J;
        end
        WT_J: state <= CAP_J;
        CAP_J: begin
          addr   <= i;
          wrdata <= rddata;
          wren   <= 1'b1;
          state  <= WR_I;
        end
        WR_I: begin
          // When i==j both writes carry the same value to the same address.
          addr   <= j;
          wrdata <= si;
          wren   <= 1'b1;
          state  <= WR_J;
        end
        WR_J: begin
          wren <= 1'b0;
          if (i == 8'(S_SIZE-1)) begin
            state <= DONE;
          end else begin
            i     <= i + 8'd1;
            addr  <= i + 8'd1;
            kidx  <= (kidx == 2'(KEY_BYTES-1)) ? 2'd0 : kidx + 2'd1;
            state <= RD_I;
          end
        end
        DONE: begin
          wren  <= 1'b0;
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: begin
          wren  <= 1'b0;
          rdy   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_ksa.sv
// Bench for arc4_ksa: behavioural s_mem plus a software KSA reference.
module tb_arc4_ksa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arc4_ksa dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  // s_mem: registered address, write on the edge with wren=1; bulk preload via ld.
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic [7:0] wa  [16384];
  logic [7:0] addr_q = 8'd0;
  logic       ld = 1'b0;
  int         wr_cnt = 0;

  always @(posedge clk) begin
    if (ld) begin
      for (int a = 0; a < 256; a++) mem[a] <= img[a];
    end else if (wren) begin
      mem[addr]            <= wrdata;
      wa[wr_cnt % 16384]   <= addr;
      wr_cnt               <= wr_cnt + 1;
    end
    addr_q <= addr;
  end
  assign rddata = mem[addr_q];

  logic [7:0] rs    [256];
  logic [7:0] rj    [256];
  logic [7:0] clean [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Software ARC4 KSA over the preload image.
  task automatic model(input logic [23:0] k);
    int jj, t, kb;
    for (int a = 0; a < 256; a++) rs[a] = img[a];
    jj = 0;
    for (int ii = 0; ii < 256; ii++) begin
      kb = (int'(k) >> (8 * (2 - ii % 3))) & 255;
      jj = (jj + int'(rs[ii]) + kb) % 256;
      t = int'(rs[ii]); rs[ii] = rs[jj]; rs[jj] = 8'(t);
      rj[ii] = 8'(jj);
    end
  endtask

  task automatic load(input bit ident);
    int r;
    logic [7:0] t;
    for (int a = 0; a < 256; a++) img[a] = 8'(a);
    if (!ident) begin
      for (int a = 255; a > 0; a--) begin
        r = $urandom_range(a, 0);
        t = img[a]; img[a] = img[r]; img[r] = t;
      end
    end
    @(negedge clk); ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask

  task automatic run(input logic [23:0] k, input bit hold, input bit early,
                     output int cyc, output int base);
    bit s0, s1, s2;
    s0 = 0; s1 = 0; s2 = 0;
    @(negedge clk); key = k; en = 1'b1; base = wr_cnt;
    @(negedge clk); if (!hold) en = 1'b0;
    chk("rdy_drop", rdy, 0);
    cyc = 1;
    while (!rdy && cyc < 2500) begin
      if (early) begin
        if (wr_cnt - base == 2 && !s0) begin
          s0 = 1;
          chk("it0_j", wa[(base + 1) % 16384], 8'h00);
          chk("it0_s0", mem[0], 8'h00);
          chk("it0_s1", mem[1], 8'h01);
        end
        if (wr_cnt - base == 4 && !s1) begin
          s1 = 1;
          chk("it1_j", wa[(base + 3) % 16384], 8'h04);
          chk("it1_s1", mem[1], 8'h04);
          chk("it1_s4", mem[4], 8'h01);
        end
        if (wr_cnt - base == 6 && !s2) begin
          s2 = 1;
          chk("it2_j", wa[(base + 5) % 16384], 8'h42);
          chk("it2_s2", mem[2], 8'h42);
          chk("it2_s42", mem[8'h42], 8'h02);
        end
      end
      @(negedge clk); cyc++;
    end
    en = 1'b0;
    chk("latency_ok", cyc <= 1900, 1);
  endtask

  task automatic final_chk(input int base);
    int bad, jbad, dup;
    bit seen [256];
    bad = 0; jbad = 0; dup = 0;
    for (int a = 0; a < 256; a++) seen[a] = 0;
    for (int a = 0; a < 256; a++) begin
      if (mem[a] !== rs[a]) bad++;
      if (wa[(base + 2*a + 1) % 16384] !== rj[a]) jbad++;
      if (seen[mem[a]]) dup++;
      seen[mem[a]] = 1;
    end
    chk("s_vs_model", bad, 0);
    chk("j_vs_model", jbad, 0);
    chk("permutation", dup, 0);
    chk("write_count", wr_cnt - base, 512);
  endtask

  initial begin
    int cyc, base, bad, w0;
    logic [23:0] rk;
    rst_n = 1'b0; en = 1'b1; key = 24'h0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 1);
    chk("rst_wren", wren, 0);
    chk("rst_nowrites", wr_cnt, 0);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rdy", rdy, 1);
    chk("idle_nowrites", wr_cnt, 0);

    // Reference key on identity S, with early-iteration checks.
    load(1); model(24'h00033C);
    run(24'h00033C, 0, 1, cyc, base);
    final_chk(base);
    for (int a = 0; a < 256; a++) clean[a] = rs[a];

    // en held high through the whole run.
    load(1); model(24'h00033C);
    run(24'h00033C, 1, 0, cyc, base);
    final_chk(base);
    w0 = wr_cnt;
    repeat (20) @(negedge clk);
    chk("hold_no_restart", wr_cnt, w0);
    chk("hold_rdy", rdy, 1);

    // Asynchronous abort mid-run, then a clean rerun.
    load(1);
    @(negedge clk); key = 24'h00033C; en = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rdy", rdy, 1);
    chk("abort_wren", wren, 0);
    @(negedge clk); rst_n = 1'b1;
    load(1); model(24'h00033C);
    run(24'h00033C, 0, 0, cyc, base);
    final_chk(base);
    bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== clean[a]) bad++;
    chk("rerun_vs_clean", bad, 0);

    // All-zero key: includes i==j steps.
    load(1); model(24'h000000);
    run(24'h000000, 0, 0, cyc, base);
    final_chk(base);

    // Random keys over random preloaded permutations.
    for (int n = 0; n < 4; n++) begin
      rk = 24'($urandom);
      load(0); model(rk);
      run(rk, n[0], 0, cyc, base);
      final_chk(base);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arc4_ksa.md
Name: arc4_ksa

Overview:
- Key-scheduling stage of the ARC4 decryption circuit.
- Runs the ARC4 KSA swap loop over a 256x8 S-array held in external single-port synchronous RAM (s_mem). The RAM is already preloaded, normally with S[i]=i.
- Uses a 24-bit key and an en/rdy handshake.
- Sits between the S-array init stage and the PRGA stage; it drives s_mem's address, data and write-enable ports.

Parameters:
- KEY_BYTES, 3, key length in bytes; key byte k is key[8*(KEY_BYTES-1-k)+:8], i.e. byte 0 is key[23:16].

Ports:
- clk     in   1   rising-edge clock
- rst_n   in   1   asynchronous active-low reset
- en      in   1   start request; sampled only while rdy=1
- rdy     out  1   1 = idle and able to accept en
- key     in   24  ARC4 key; latched on start
- addr    out  8   s_mem address
- rddata  in   8   s_mem q
- wrdata  out  8   s_mem write data
- wren    out  1   s_mem write enable

Behaviour:
- s_mem contract: 256x8 single-port RAM, port order (address, clock, data, wren, q).
  - Address and data are registered on the rising clk edge.
  - q for the address presented in cycle t is valid in cycle t+1 and is sampled at the end of t+1, so there is one wait state per read.
  - A write takes effect at the edge where wren=1.
- Reset (async, rst_n=0), all registers:
  - state=IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=0, j=0.
  - S contents are not restored; a mid-run reset leaves S partially permuted and aborts the run.
- Start: in IDLE with rdy=1 and en=1 at a rising edge:
  - latch key, set i=0 and j=0, drop rdy to 0.
  - en is ignored while rdy=0. en may stay high or drop after the start edge with no effect.
- Per iteration, all arithmetic mod 256 (8-bit wrap):
  - RD_I: addr=i, wren=0.
  - WT_I: wait.
  - CAP_I: si=rddata; j_next = j + si + keybyte[i mod 3]; addr=j_next.
  - WT_J: wait.
  - CAP_J: sj=rddata.
  - WR_I: addr=i, wrdata=sj, wren=1.
  - WR_J: addr=j, wrdata=si, wren=1.
  - Then if i==255 go to DONE, else i=i+1 and go to RD_I.
  - At most 7 cycles per iteration.
- i mod 3: keep a 2-bit counter kidx (0,1,2 wrap) advanced with i; no divider.
- When i==j, both writes target the same address with the same value; the result is correct with no special case.
- DONE: wren=0, rdy=1, return to IDLE. Total start-to-rdy latency is at most 1900 cycles.
- wren is asserted only in WR_I and WR_J, never in IDLE. addr and wrdata are don't-care when wren=0.

Decomposition:
- Shared package arc4_pkg:
  - state enum ksa_state_t {IDLE, RD_I, WT_I, CAP_I, WT_J, CAP_J, WR_I, WR_J, DONE}
  - constants KEY_BYTES=3, S_SIZE=256
  - function key_byte(key, idx)
- Single FSM module with no sub-modules. s_mem is instantiated by the parent or testbench, not inside arc4_ksa.

Test Plan:
- Reset handshake: rst_n=0 with en=1, then release → rdy=1, wren=0, no memory writes before en is sampled with rdy=1.
- Start, S preloaded with identity, key=24'h00033C, en pulsed one cycle → rdy=0 the next cycle. Checks after each iteration:
  - after i=0: j=0, S unchanged
  - after i=1: j=4, S[1]=4 and S[4]=1
  - after i=2: j=0x42, S[2]=0x42 and S[0x42]=2
- Completion, same run → rdy=1 within 1900 cycles of start. Final S equals a software ARC4 KSA model for key 00033C and is a permutation of 0..255.
- en held high throughout the run → no restart; exactly 512 write cycles per run, and rdy returns to 1.
- Reset at about cycle 500 of a run → rdy=1 and wren=0 immediately (async). A new start with the same key and a reloaded identity S gives the same final S as the clean run.
- key=24'h000000 with identity S → output matches the software model, including i==j iterations (e.g. i=0, j=0) that leave values unchanged.
